mux_stream_rr: RTL
==================

MUX_STREAM_RR -- requirements
Module: mux_stream_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning data bits per channel.
REQ-002 SHALL have parameter N_IN, default 4, range 2..16, meaning number of input channels.
REQ-003 SHALL have parameter SEL_WIDTH, default $clog2(N_IN), meaning width of sel and out_chan.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning synchronous active-low reset.
REQ-006 SHALL have port mode, input, 1, meaning 0 = explicit select via sel, 1 = round-robin arbitration.
REQ-007 SHALL have port sel, input, SEL_WIDTH, meaning channel index used when mode=0.
REQ-008 SHALL have port in_data, input, N_IN*WIDTH, meaning channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port in_valid, input, N_IN, meaning per-channel data valid.
REQ-010 SHALL have port in_ready, output, N_IN, meaning per-channel accept; one-hot or zero.
REQ-011 SHALL have port out_data, output, WIDTH, meaning registered selected data.
REQ-012 SHALL have port out_chan, output, SEL_WIDTH, meaning source index of out_data.
REQ-013 SHALL have port out_valid, output, 1, meaning out_data/out_chan valid.
REQ-014 SHALL have port out_ready, input, 1, meaning downstream accept.

Function
REQ-015 Transfer on a port SHALL occur when valid and ready are both high at a rising clk edge.
REQ-016 load_en SHALL be (!out_valid || out_ready); output register loads only when load_en and a grant exists.
REQ-017 Latency SHALL be one cycle: input transfer in cycle t gives out_valid=1 with that data in cycle t+1.
REQ-018 Full throughput: one transfer per cycle when out_ready held high and any in_valid high.
REQ-019 mode=0: grant SHALL go to channel sel iff in_valid[sel]; sel >= N_IN SHALL give no grant.
REQ-020 mode=1: grant SHALL go to the first valid channel searching ptr, ptr+1, ... wrapping modulo N_IN.
REQ-021 ptr SHALL update to (granted+1) mod N_IN only on an input transfer in mode=1; unchanged otherwise.
REQ-022 in_ready[g] SHALL equal load_en && grant==g; all others 0; in_ready never depends on out_valid of a stalled load.
REQ-023 Stall (out_valid=1, out_ready=0): out_data, out_chan, out_valid SHALL hold; all in_ready=0.
REQ-024 No grant and out_ready=1 with out_valid=1: out_valid SHALL drop to 0 next cycle; out_data holds last value.
REQ-025 Mode or sel change SHALL affect only the next grant; a held output word is never altered.
REQ-026 Single valid channel in mode=1 SHALL be granted every cycle regardless of ptr.

Reset
REQ-027 rst_n=0 at a clk edge SHALL set out_valid=0, out_data=0, out_chan=0, ptr=0.
REQ-028 While rst_n=0, in_ready SHALL be all zero; reset mid-stall SHALL discard the held word.
REQ-029 First grant after reset in mode=1 SHALL start search at channel 0.

Structure
REQ-030 Shared package SHALL hold mode encodings (MODE_SEL=0, MODE_RR=1) and default WIDTH/N_IN constants.
REQ-031 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req, ptr; outputs grant index, grant_valid).
REQ-032 Top SHALL contain only pointer register, output register, mode mux and handshake logic.

Verification
REQ-033 Reset, then mode=0, sel=2, in_valid=4'b0100, ch2=16'hBEEF, out_ready=1 -> next cycle out_data=16'hBEEF, out_chan=2, out_valid=1.
REQ-034 mode=1, in_valid=4'b1111, out_ready=1, 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3.
REQ-035 mode=1, in_valid=4'b1010 after ptr=0 -> out_chan 1,3,1,3; in_ready[0],[2] never high.
REQ-036 Output held with out_ready=0 for 3 cycles while inputs change -> out_data/out_chan constant, in_ready=0; release -> held word transfers once, no loss or duplication.
REQ-037 mode=0, sel=3, in_valid[3]=0, other channels valid -> no transfer, out_valid falls to 0 after current word consumed.
REQ-038 rst_n=0 for one cycle during stall -> out_valid=0, out_data=0, next mode=1 grant starts at channel 0.

Source files
------------

// File: rtl/mux_stream_rr_pkg.sv
// Shared definitions for the stream multiplexer: mode encodings and default sizing.
package mux_stream_rr_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_N_IN  = 4;

endpackage

// File: rtl/mux_stream_rr_arbiter.sv
// Round-robin grant search: first asserted request starting at ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] grant,
    output logic          grant_valid
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;

    // Rotating right by ptr puts the highest-priority request at bit 0.
    assign doubled = {req, req} >> ptr;
    assign rotated = doubled[N-1:0];

    always_comb begin
        int unsigned idx;
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!grant_valid && rotated[k]) begin
                idx = 32'(ptr) + k;
                if (idx >= N) idx = idx - N;
                grant       = PW'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_stream_rr.sv
// N-input stream multiplexer with explicit-select or round-robin grant and a
// single registered output stage with valid/ready handshakes on both sides.
module mux_stream_rr
    import mux_stream_rr_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int N_IN      = DEFAULT_N_IN,
    parameter int SEL_WIDTH = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_WIDTH-1:0]  sel,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_WIDTH-1:0]  out_chan,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [SEL_WIDTH-1:0] ptr;
    logic [SEL_WIDTH-1:0] ptr_next;
    logic [SEL_WIDTH-1:0] rr_grant;
    logic                 rr_valid;
    logic [SEL_WIDTH-1:0] grant;
    logic                 grant_valid;
    logic                 sel_valid;
    logic [WIDTH-1:0]     grant_data;
    logic                 load_en;
    logic                 xfer;
    logic                 rr_mode;

    rr_arbiter #(
        .N  (N_IN),
        .PW (SEL_WIDTH)
    ) u_arb (
        .req         (in_valid),
        .ptr         (ptr),
        .grant       (rr_grant),
        .grant_valid (rr_valid)
    );

    assign rr_mode = (mode_e'(mode) == MODE_RR);
    assign load_en = !out_valid || out_ready;

    // Out-of-range sel matches no channel, so it never produces a grant.
    always_comb begin
        sel_valid = 1'b0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (sel == SEL_WIDTH'(i)) sel_valid = in_valid[i];
        end
    end

    assign grant       = rr_mode ? rr_grant : sel;
    assign grant_valid = rr_mode ? rr_valid : sel_valid;
    assign xfer        = rst_n && load_en && grant_valid;
    assign ptr_next    = (grant == SEL_WIDTH'(N_IN - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (grant == SEL_WIDTH'(i)) begin
                grant_data  = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = xfer;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            ptr       <= '0;
        end else begin
            if (load_en) begin
                out_valid <= grant_valid;
                if (grant_valid) begin
                    out_data <= grant_data;
                    out_chan <= grant;
                end
            end
            if (xfer && rr_mode) ptr <= ptr_next;
        end
    end

endmodule
